// File: rtl/lc3b_types.sv
// -----------------------------------------------------------------------------
// lc3b_types
// Shared types for the instruction-fetch datapath.
//   fetch_state_t : the five fetch FSM states
//   IR_VALID_W    : width of the ir_valid strobe
//   MEM_REQ_W     : width of the memory read request
// -----------------------------------------------------------------------------
package lc3b_types;

   typedef enum logic [2:0] {
      HALT   = 3'd0,
      FETCH1 = 3'd1,
      FETCH2 = 3'd2,
      FETCH3 = 3'd3,
      PAUSE  = 3'd4
   } fetch_state_t;

   localparam int IR_VALID_W = 1;
   localparam int MEM_REQ_W  = 1;

endpackage

// File: rtl/fetch_datapath_reg.sv
// -----------------------------------------------------------------------------
// fetch_datapath_reg
// Load-enabled register with synchronous active-low reset, shared by PC, MAR,
// MDR and IR.
//   Clk    : clock, rising edge
//   Reset  : synchronous active-low reset, forces q_o to RESET_VAL
//   load_i : capture d_i on the next rising edge
//   d_i    : next value
//   q_o    : stored value
// -----------------------------------------------------------------------------
module fetch_datapath_reg #(
   parameter int           W         = 16,
   parameter logic [W-1:0] RESET_VAL = '0
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         load_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] q_q;

   // NOTE: sequential state uses non-blocking assignment so every register
   // samples its inputs from the same pre-edge values.
   always_ff @(posedge Clk) begin
      // NOTE: reset has priority over load, so a load request (e.g. a memory
      // completion) arriving in the reset cycle is discarded.
      if (!Reset) begin
         q_q <= RESET_VAL;
      end else if (load_i) begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/fetch_datapath.sv
// -----------------------------------------------------------------------------
// fetch_datapath
// Instruction-fetch FSM with PC, MAR, MDR and IR registers.
//   Clk            : clock, rising edge
//   Reset          : synchronous active-low reset
//   Run            : level; starts fetching from HALT, low in PAUSE -> HALT
//   Continue       : level; its rising edge releases PAUSE
//   redirect_valid : in PAUSE, load PC from redirect_addr
//   redirect_addr  : branch/jump target
//   mem_rdata      : memory read data
//   mem_ready      : memory completion, only looked at in FETCH2
//   mem_addr       : MAR contents
//   mem_req        : read request, high in FETCH2
//   pc_out         : current PC
//   mdr_out        : current MDR
//   ir_out         : current IR
//   ir_valid       : one-cycle pulse when IR has just been loaded
//   busy           : high in FETCH1..FETCH3
// -----------------------------------------------------------------------------
module fetch_datapath
   import lc3b_types::*;
#(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 20,
   parameter logic [DATA_W-1:0] PC_RESET = '0
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Run,
   input  logic                  Continue,
   input  logic                  redirect_valid,
   input  logic [DATA_W-1:0]     redirect_addr,
   input  logic [DATA_W-1:0]     mem_rdata,
   input  logic                  mem_ready,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [MEM_REQ_W-1:0]  mem_req,
   output logic [DATA_W-1:0]     pc_out,
   output logic [DATA_W-1:0]     mdr_out,
   output logic [DATA_W-1:0]     ir_out,
   output logic [IR_VALID_W-1:0] ir_valid,
   output logic                  busy
);

   fetch_state_t          state_q;
   logic                  cont_q;
   logic [MEM_REQ_W-1:0]  mem_req_q;
   logic [IR_VALID_W-1:0] ir_valid_q;
   logic                  busy_q;

   logic                  cont_edge;
   logic [DATA_W-1:0]     pc_q, pc_d, mdr_q, ir_q;
   logic [ADDR_W-1:0]     mar_q, mar_d;
   logic                  pc_load, mar_load, mdr_load, ir_load;

   // Previous Continue is tracked in every state, so a level held through a
   // fetch does not look like a fresh edge once PAUSE is reached.
   assign cont_edge = Continue & ~cont_q;

   // FSM with registered outputs: mem_req/busy follow the state being
   // entered, ir_valid flags the cycle right after FETCH3.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q    <= HALT;
         cont_q     <= 1'b0;
         mem_req_q  <= '0;
         ir_valid_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         cont_q     <= Continue;
         ir_valid_q <= '0;
         case (state_q)
            HALT: begin
               if (Run) begin
                  state_q <= FETCH1;
                  busy_q  <= 1'b1;
               end
            end
            FETCH1: begin
               state_q   <= FETCH2;
               mem_req_q <= '1;
            end
            FETCH2: begin
               if (mem_ready) begin
                  state_q   <= FETCH3;
                  mem_req_q <= '0;
               end
            end
            FETCH3: begin
               state_q    <= PAUSE;
               busy_q     <= 1'b0;
               ir_valid_q <= '1;
            end
            PAUSE: begin
               if (!Run) begin
                  state_q <= HALT;
               end else if (cont_edge) begin
                  state_q <= FETCH1;
                  busy_q  <= 1'b1;
               end
            end
            default: begin
               state_q   <= HALT;
               mem_req_q <= '0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   // Next-PC mux: a redirect in PAUSE wins regardless of Run/Continue;
   // otherwise FETCH1 increments with natural wrap at 2^DATA_W.
   assign pc_load  = (state_q == FETCH1) || ((state_q == PAUSE) && redirect_valid);
   assign pc_d     = (state_q == PAUSE) ? redirect_addr : pc_q + DATA_W'(1);

   assign mar_load = (state_q == FETCH1);
   assign mar_d    = ADDR_W'(pc_q);

   assign mdr_load = (state_q == FETCH2) && mem_ready;
   assign ir_load  = (state_q == FETCH3);

   fetch_datapath_reg #(.W(DATA_W), .RESET_VAL(PC_RESET)) u_pc (
      .Clk(Clk), .Reset(Reset), .load_i(pc_load), .d_i(pc_d), .q_o(pc_q)
   );

   fetch_datapath_reg #(.W(ADDR_W), .RESET_VAL('0)) u_mar (
      .Clk(Clk), .Reset(Reset), .load_i(mar_load), .d_i(mar_d), .q_o(mar_q)
   );

   fetch_datapath_reg #(.W(DATA_W), .RESET_VAL('0)) u_mdr (
      .Clk(Clk), .Reset(Reset), .load_i(mdr_load), .d_i(mem_rdata), .q_o(mdr_q)
   );

   fetch_datapath_reg #(.W(DATA_W), .RESET_VAL('0)) u_ir (
      .Clk(Clk), .Reset(Reset), .load_i(ir_load), .d_i(mdr_q), .q_o(ir_q)
   );

   assign mem_addr = mar_q;
   assign mem_req  = mem_req_q;
   assign pc_out   = pc_q;
   assign mdr_out  = mdr_q;
   assign ir_out   = ir_q;
   assign ir_valid = ir_valid_q;
   assign busy     = busy_q;

endmodule
